sysbus_arbiter: RTL and testbench

Round-robin arbiter that shares the single system-bus port among the core's bus masters: page-table walker, instruction/data fetch, and store write-back. It sits between those requesters and the bus interface and issues a one-hot grant. A granted master holds the bus for as long as it drives its busy line, so multi-beat bursts are never interleaved. It replaces the fixed-priority arbitration in the top level, bounds starvation, and flags protocol violations and hung transactions.

---
 rtl/sysbus_arb_pkg.sv | 25 ++
 rtl/sysbus_arbiter_if.sv | 42 ++++
 rtl/rr_pick.sv | 46 ++++
 rtl/sysbus_arbiter.sv | 138 +++++++++++++
 tb/tb_sysbus_arbiter.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/sysbus_arb_pkg.sv
// -----------------------------------------------------------------------------
// sysbus_arb_pkg
// Shared types and constants for the system-bus arbiter:
//   - arb_state_t : arbiter FSM states
//   - REQ_*       : requester index assignments
//   - DEF_*       : default geometry used by the interface and the top
// -----------------------------------------------------------------------------
package sysbus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        OWNED   = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Requester indices on the req/busy/grant vectors.
    localparam int REQ_PTW   = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_STORE = 2;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ID_W    = 2;

endpackage : sysbus_arb_pkg

// File: rtl/sysbus_arbiter_if.sv
// -----------------------------------------------------------------------------
// sysbus_arbiter_if
// Handshake between the bus masters and the arbiter.
//   req       : per-requester bus request (level)
//   busy      : per-requester transaction in flight (level)
//   grant     : one-hot grant from the arbiter
//   grant_id  : index of the current or last grant holder
//   bus_owned : bus is granted (GRANT or OWNED)
// Modports:
//   master : arbiter side (drives grant/grant_id/bus_owned)
//   slave  : requester side (drives req/busy)
// -----------------------------------------------------------------------------
interface sysbus_arbiter_if
    import sysbus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] busy;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               bus_owned;

    modport master (
        input  req,
        input  busy,
        output grant,
        output grant_id,
        output bus_owned
    );

    modport slave (
        output req,
        output busy,
        input  grant,
        input  grant_id,
        input  bus_owned
    );

endinterface : sysbus_arbiter_if

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin selector. The search starts at last+1 (mod
// NUM_REQ) and wraps around, so the most recent holder has lowest priority.
//   req    : request vector
//   last   : index of the previous grant holder
//   valid  : at least one request is pending
//   winner : selected requester index (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_pick
    import sysbus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               valid,
    output logic [ID_W-1:0]    winner
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] rotated;
    logic [ID_W-1:0]      start;

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        start   = (int'(last) >= NUM_REQ - 1) ? '0 : last + 1'b1;
        // Doubling the vector makes the rotation a plain right shift:
        // bits [NUM_REQ-1:0] of the result are req rotated by start.
        doubled = {req, req};
        rotated = doubled >> start;
        valid   = 1'b0;
        winner  = '0;
        // Scan downwards so the lowest rotated position (closest to start)
        // is the last one written and therefore wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                valid  = 1'b1;
                winner = ID_W'((int'(start) + i) % NUM_REQ);
            end
        end
    end

endmodule : rr_pick

// File: rtl/sysbus_arbiter.sv
// -----------------------------------------------------------------------------
// sysbus_arbiter
// Round-robin owner of the single system-bus port. A granted master keeps the
// bus for as long as it holds its busy line, so bursts are never split. A
// RELEASE cycle between owners provides bus turnaround.
// Ports:
//   clk          : system clock, rising edge
//   reset        : asynchronous, active-low
//   bus          : req/busy in, grant/grant_id/bus_owned out (master modport)
//   protocol_err : sticky, busy seen from a requester that holds no grant
//   timeout_err  : sticky, one ownership lasted TIMEOUT_CYCLES cycles
//   timeout_id   : grant_id at the moment timeout_err was set
// A timeout is reported only; the grant is never revoked.
// -----------------------------------------------------------------------------
module sysbus_arbiter
    import sysbus_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int ID_W           = DEF_ID_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            reset,
    sysbus_arbiter_if.master bus,
    output logic            protocol_err,
    output logic            timeout_err,
    output logic [ID_W-1:0] timeout_id
);

    // Counter wide enough to hold TIMEOUT_CYCLES itself (its saturation value).
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state;
    logic [NUM_REQ-1:0] grant_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    last_q;
    logic               bus_owned_q;
    logic [CNT_W-1:0]   to_cnt;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req    (bus.req),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_id)
    );

    assign bus.grant     = grant_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.bus_owned = bus_owned_q;

    // NOTE: the reset branch is asynchronous, so outputs clear as soon as
    // reset falls without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);
            bus_owned_q  <= 1'b0;
            to_cnt       <= '0;
            protocol_err <= 1'b0;
            timeout_err  <= 1'b0;
            timeout_id   <= '0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every
            // decision in this cycle sees the state from before the edge.

            // Busy from a non-holder is flagged in every state; the FSM
            // below only ever looks at busy[grant_id], so it is ignored.
            if (|(bus.busy & ~grant_q)) begin
                protocol_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q     <= NUM_REQ'(1) << pick_id;
                        grant_id_q  <= pick_id;
                        bus_owned_q <= 1'b1;
                        state       <= GRANT;
                    end
                end

                GRANT: begin
                    if (bus.busy[grant_id_q]) begin
                        to_cnt <= '0;
                        state  <= OWNED;
                    end else if (!bus.req[grant_id_q]) begin
                        // Request withdrawn before any transfer started.
                        grant_q     <= '0;
                        bus_owned_q <= 1'b0;
                        state       <= RELEASE;
                    end
                end

                OWNED: begin
                    if (TIMEOUT_CYCLES != 0) begin
                        if (to_cnt != CNT_MAX) begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                        // to_cnt counts completed OWNED cycles, so this
                        // fires at the end of the TIMEOUT_CYCLES-th one.
                        if (to_cnt == CNT_LAST && !timeout_err) begin
                            timeout_err <= 1'b1;
                            timeout_id  <= grant_id_q;
                        end
                    end
                    // Only busy ends ownership; req may already be low.
                    if (!bus.busy[grant_id_q]) begin
                        grant_q     <= '0;
                        bus_owned_q <= 1'b0;
                        state       <= RELEASE;
                    end
                end

                RELEASE: begin
                    last_q <= grant_id_q;
                    state  <= IDLE;
                end

                default: begin
                    grant_q     <= '0;
                    bus_owned_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule : sysbus_arbiter

// File: tb/tb_sysbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sysbus_arbiter
// Directed bench for sysbus_arbiter with TIMEOUT_CYCLES = 16. Inputs change on
// the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sysbus_arbiter;
    import sysbus_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;
    localparam int TO_CYC  = 16;

    logic            clk;
    logic            reset;
    logic            protocol_err;
    logic            timeout_err;
    logic [ID_W-1:0] timeout_id;

    int checks   = 0;
    int failures = 0;

    sysbus_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus_if ();

    sysbus_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ID_W           (ID_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .protocol_err (protocol_err),
        .timeout_err  (timeout_err),
        .timeout_id   (timeout_id)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then move to the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int owned_cycles;
    int grant_bad;

    initial begin
        reset       = 1'b0;
        bus_if.req  = '0;
        bus_if.busy = '0;
        @(negedge clk);
        @(negedge clk);

        // ---- reset values
        check("rst_grant",     32'(bus_if.grant), 0);
        check("rst_grant_id",  32'(bus_if.grant_id), 0);
        check("rst_bus_owned", 32'(bus_if.bus_owned), 0);
        check("rst_perr",      32'(protocol_err), 0);
        check("rst_terr",      32'(timeout_err), 0);
        check("rst_tid",       32'(timeout_id), 0);

        // ---- all request after reset: 001, then 010, then 100
        bus_if.req = 3'b111;
        reset      = 1'b1;
        tick();
        check("rr_first_grant", 32'(bus_if.grant), 1);
        check("rr_first_id",    32'(bus_if.grant_id), REQ_PTW);
        check("rr_first_owned", 32'(bus_if.bus_owned), 1);
        bus_if.busy = 3'b001;        // same cycle the grant appears: legal
        tick();
        bus_if.busy = 3'b000;
        tick();
        check("rr_release_low", 32'(bus_if.grant), 0);
        tick();
        check("rr_idle_low", 32'(bus_if.grant), 0);
        tick();
        check("rr_second_grant", 32'(bus_if.grant), 2);
        bus_if.busy = 3'b010;
        tick();
        bus_if.busy = 3'b000;
        tick();
        tick();
        tick();
        check("rr_third_grant", 32'(bus_if.grant), 4);
        check("rr_third_id",    32'(bus_if.grant_id), REQ_STORE);
        bus_if.busy = 3'b100;
        tick();
        bus_if.busy = 3'b000;
        bus_if.req  = 3'b000;
        tick();
        tick();
        check("rr_done_owned", 32'(bus_if.bus_owned), 0);

        // ---- fetch burst: busy[1] high for 8 cycles, starting one cycle late
        bus_if.req   = 3'b010;
        owned_cycles = 0;
        grant_bad    = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            if (bus_if.bus_owned) owned_cycles++;
            if (bus_if.grant !== 3'b010) grant_bad++;
            bus_if.busy = (i >= 1 && i <= 8) ? 3'b010 : 3'b000;
            tick();
        end
        check("burst_owned_cycles", 32'(owned_cycles), 10);
        check("burst_grant_held",   32'(grant_bad), 0);
        check("burst_gap1_grant",   32'(bus_if.grant), 0);
        check("burst_gap1_owned",   32'(bus_if.bus_owned), 0);
        tick();
        check("burst_gap2_grant", 32'(bus_if.grant), 0);
        tick();
        check("burst_regrant", 32'(bus_if.grant), 2);
        bus_if.req = 3'b000;
        tick();
        tick();

        // ---- store request withdrawn in GRANT, then 111 grants 001
        bus_if.req = 3'b100;
        tick();
        check("wd_grant", 32'(bus_if.grant), 4);
        bus_if.req = 3'b000;
        tick();
        check("wd_release", 32'(bus_if.grant), 0);
        tick();
        bus_if.req = 3'b111;
        tick();
        check("wd_next_grant", 32'(bus_if.grant), 1);
        bus_if.req = 3'b000;
        tick();
        tick();

        // ---- protocol violation: busy[0] while fetch holds the grant
        check("perr_clean", 32'(protocol_err), 0);
        bus_if.req = 3'b010;
        tick();
        check("perr_grant", 32'(bus_if.grant), 2);
        bus_if.busy = 3'b001;
        tick();
        check("perr_set",        32'(protocol_err), 1);
        check("perr_grant_kept", 32'(bus_if.grant), 2);
        bus_if.busy = 3'b000;
        tick();
        check("perr_sticky",     32'(protocol_err), 1);
        check("perr_grant_hold", 32'(bus_if.grant), 2);
        bus_if.req = 3'b000;
        tick();
        tick();

        // ---- timeout: busy[1] held for 20 cycles, req dropped early
        bus_if.req = 3'b010;
        tick();
        check("to_grant", 32'(bus_if.grant), 2);
        bus_if.busy = 3'b010;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) bus_if.req = 3'b000;
            tick();
            if (i == 16) check("to_not_yet", 32'(timeout_err), 0);
            if (i == 17) begin
                check("to_set", 32'(timeout_err), 1);
                check("to_id",  32'(timeout_id), REQ_FETCH);
            end
        end
        check("to_grant_kept", 32'(bus_if.grant), 2);
        bus_if.busy = 3'b000;
        tick();
        check("to_released", 32'(bus_if.grant), 0);
        check("to_sticky",   32'(timeout_err), 1);
        tick();

        // ---- asynchronous reset in OWNED
        bus_if.req = 3'b001;
        tick();
        check("ar_grant", 32'(bus_if.grant), 1);
        bus_if.busy = 3'b001;
        tick();
        #2;
        reset = 1'b0;
        #1;
        check("ar_grant_clr", 32'(bus_if.grant), 0);
        check("ar_owned_clr", 32'(bus_if.bus_owned), 0);
        check("ar_perr_clr",  32'(protocol_err), 0);
        check("ar_terr_clr",  32'(timeout_err), 0);
        check("ar_tid_clr",   32'(timeout_id), 0);
        bus_if.busy = 3'b000;
        bus_if.req  = 3'b000;
        @(negedge clk);
        bus_if.req = 3'b111;
        reset      = 1'b1;
        tick();
        check("ar_last_restored", 32'(bus_if.grant), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sysbus_arbiter
